// File: rtl/cpu_step_monitor_if.sv
// Board-side bus of the CPU step monitor: button, display select,
// CPU observation buses and the step/display outputs.
interface cpu_step_monitor_if;
  logic        step_btn;
  logic [1:0]  sel;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] result;
  logic        cpu_step;
  logic [15:0] step_count;
  logic [31:0] shown;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport slave (
    input  step_btn, sel, pc, inst, result,
    output cpu_step, step_count, shown, an, seg
  );

  modport master (
    output step_btn, sel, pc, inst, result,
    input  cpu_step, step_count, shown, an, seg
  );
endinterface

// File: rtl/cpu_step_monitor.sv
// Debounced single-step pulse generator, step counter and
// 8-digit multiplexed hex display of a selected CPU bus.
module cpu_step_monitor #(
  parameter int SCAN_DIV  = 50000,
  parameter int DB_CYCLES = 1000000
) (
  input logic               clk,
  input logic               reset,
  cpu_step_monitor_if.slave bus
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int SCW = $clog2(SCAN_DIV);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } db_state_t;

  logic            r_s1;
  logic            r_s2;
  db_state_t       r_state;
  logic [DBW-1:0]  r_cnt;
  logic            r_cpu_step;
  logic [15:0]     r_step_count;
  logic [SCW-1:0]  r_scan;
  logic [2:0]      r_digit;
  logic [31:0]     r_shown;
  logic [7:0]      r_an;
  logic [7:0]      r_seg;

  db_state_t       w_state_nx;
  logic [DBW-1:0]  w_cnt_nx;
  logic            w_pulse_nx;
  logic            w_scan_tc;
  logic            w_frame;
  logic [31:0]     w_src;
  logic [3:0]      w_nib;
  logic [7:0]      w_pat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.step_btn;
      r_s2 <= r_s1;
    end
  end

  // Reset lands in RELEASE so a button held through reset
  // must be seen low for a full debounce window first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RELEASE;
      r_cnt      <= '0;
      r_cpu_step <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_cpu_step <= w_pulse_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pulse_nx = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_s2) begin
          w_state_nx = CONFIRM;
          w_cnt_nx   = '0;
        end
      end
      CONFIRM: begin
        if (!r_s2) begin
          w_state_nx = IDLE;
        end else if (r_cnt == DB_MAX) begin
          w_state_nx = HELD;
          w_pulse_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!r_s2) begin
          w_state_nx = RELEASE;
          w_cnt_nx   = '0;
        end
      end
      RELEASE: begin
        if (r_s2) begin
          w_state_nx = HELD;
        end else if (r_cnt == DB_MAX) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_count <= '0;
    end else if (r_cpu_step) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign w_scan_tc = (r_scan == SC_MAX);
  assign w_frame   = w_scan_tc && (r_digit == 3'd7);

  always_comb begin
    w_src = r_shown;
    unique case (bus.sel)
      2'b00:   w_src = bus.pc;
      2'b01:   w_src = bus.inst;
      2'b10:   w_src = bus.result;
      default: w_src = {16'h0000, r_step_count};
    endcase
  end

  assign w_nib = r_shown[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_pat = 8'h00;
    unique case (w_nib)
      4'h0:    w_pat = 8'h3F;
      4'h1:    w_pat = 8'h06;
      4'h2:    w_pat = 8'h5B;
      4'h3:    w_pat = 8'h4F;
      4'h4:    w_pat = 8'h66;
      4'h5:    w_pat = 8'h6D;
      4'h6:    w_pat = 8'h7D;
      4'h7:    w_pat = 8'h07;
      4'h8:    w_pat = 8'h7F;
      4'h9:    w_pat = 8'h6F;
      4'hA:    w_pat = 8'h77;
      4'hB:    w_pat = 8'h7C;
      4'hC:    w_pat = 8'h39;
      4'hD:    w_pat = 8'h5E;
      4'hE:    w_pat = 8'h79;
      default: w_pat = 8'h71;
    endcase
  end

  // shown only reloads at the frame wrap so every frame is
  // one consistent snapshot; an/seg trail digit by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan  <= '0;
      r_digit <= 3'd0;
      r_shown <= '0;
      r_an    <= 8'hFE;
      r_seg   <= 8'hC0;
    end else begin
      r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
      if (w_scan_tc) begin
        r_digit <= r_digit + 3'd1;
      end
      if (w_frame) begin
        r_shown <= w_src;
      end
      r_an  <= ~(8'b1 << r_digit);
      r_seg <= ~w_pat;
    end
  end

  assign bus.cpu_step   = r_cpu_step;
  assign bus.step_count = r_step_count;
  assign bus.shown      = r_shown;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;

endmodule

// File: tb/tb_cpu_step_monitor.sv
// Directed bench for cpu_step_monitor: step debounce timing,
// counter wrap, reset behaviour and the scanned hex display.
module tb_cpu_step_monitor;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_step_monitor_if mif ();

  cpu_step_monitor #(
    .SCAN_DIV (4),
    .DB_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif.slave)
  );

  typedef struct packed {
    logic [1:0]      sel;
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic [31:0]     result;
    logic [31:0]     shown;
    logic [7:0][7:0] seg;
  } dvec_t;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  always @(posedge clk) begin
    if (mif.cpu_step === 1'b1) npulse++;
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(logic [7:0] v, string name);
    int n;
    n = 0;
    while (mif.an !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout actual=%h required=%h",
               name, mif.an, v);
    end
  endtask

  // Button held high from the current negedge; pulse expected
  // after edge pe, step_count == cnt after edge pe+1.
  task automatic press(string name, int pe, int n,
                       logic [15:0] cnt);
    mif.step_btn = 1'b1;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      chk({name, "_step"}, 32'(mif.cpu_step), 32'(e == pe));
      if (e > pe) chk({name, "_cnt"}, 32'(mif.step_count),
                      32'(cnt));
    end
  endtask

  dvec_t      vt [4];
  logic [7:0] an_exp [8];
  logic       bp [6];
  int         p0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd0, 32'h0040_0010, 32'h1111_1111,
              32'h2222_2222, 32'h0040_0010,
              {8'hC0, 8'hC0, 8'h99, 8'hC0,
               8'hC0, 8'hC0, 8'hF9, 8'hC0}};
    vt[1] = '{2'd1, 32'h0000_0000, 32'h89AB_CDEF,
              32'h2222_2222, 32'h89AB_CDEF,
              {8'h80, 8'h90, 8'h88, 8'h83,
               8'hC6, 8'hA1, 8'h86, 8'h8E}};
    vt[2] = '{2'd2, 32'h0000_0000, 32'h0000_0000,
              32'h7654_3210, 32'h7654_3210,
              {8'hF8, 8'h82, 8'h92, 8'h99,
               8'hB0, 8'hA4, 8'hF9, 8'hC0}};
    vt[3] = '{2'd3, 32'h0000_0000, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0003,
              {8'hC0, 8'hC0, 8'hC0, 8'hC0,
               8'hC0, 8'hC0, 8'hC0, 8'hB0}};
    an_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset        = 1'b1;
    mif.step_btn = 1'b0;
    mif.sel      = 2'd0;
    mif.pc       = '0;
    mif.inst     = '0;
    mif.result   = '0;
    tick(3);
    chk("rst_step", 32'(mif.cpu_step), 32'd0);
    chk("rst_cnt", 32'(mif.step_count), 32'd0);
    chk("rst_shown", mif.shown, 32'd0);
    chk("rst_an", 32'(mif.an), 32'hFE);
    chk("rst_seg", 32'(mif.seg), 32'hC0);
    reset = 1'b0;

    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) chk("slot0_an", 32'(mif.an), 32'hFE);
      if (k == 5) chk("slot1_an", 32'(mif.an), 32'hFD);
      chk("idle_seg", 32'(mif.seg), 32'hC0);
      chk("idle_step", 32'(mif.cpu_step), 32'd0);
    end

    press("clean1", 7, 20, 16'h0001);
    mif.step_btn = 1'b0;
    tick(10);
    press("clean2", 7, 10, 16'h0002);
    mif.step_btn = 1'b0;
    tick(10);

    p0 = npulse;
    for (int e = 1; e <= 20; e++) begin
      mif.step_btn = (e <= 6) ? bp[e-1] : 1'b1;
      @(negedge clk);
      chk("bounce_step", 32'(mif.cpu_step), 32'(e == 12));
    end
    chk("bounce_npulse", 32'(npulse - p0), 32'd1);
    chk("bounce_cnt", 32'(mif.step_count), 32'h0003);
    mif.step_btn = 1'b0;
    tick(10);

    for (int i = 0; i < 4; i++) begin
      mif.sel    = vt[i].sel;
      mif.pc     = vt[i].pc;
      mif.inst   = vt[i].inst;
      mif.result = vt[i].result;
      tick(20);
      if (i > 0) chk("disp_hold", mif.shown, vt[i-1].shown);
      tick(30);
      chk("disp_shown", mif.shown, vt[i].shown);
      wait_an(8'h7F, "sync7");
      wait_an(8'hFE, "sync0");
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 4; c++) begin
          chk("disp_an", 32'(mif.an), 32'(an_exp[d]));
          chk("disp_seg", 32'(mif.seg), 32'(vt[i].seg[d]));
          @(negedge clk);
        end
      end
    end

    mif.step_btn = 1'b1;
    tick(4);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_step", 32'(mif.cpu_step), 32'd0);
    chk("mrst_cnt", 32'(mif.step_count), 32'd0);
    chk("mrst_shown", mif.shown, 32'd0);
    chk("mrst_an", 32'(mif.an), 32'hFE);
    chk("mrst_seg", 32'(mif.seg), 32'hC0);
    reset = 1'b0;
    p0 = npulse;
    tick(20);
    chk("mrst_nopulse", 32'(npulse - p0), 32'd0);
    mif.step_btn = 1'b0;
    tick(10);
    press("mrst_press", 7, 10, 16'h0001);
    mif.step_btn = 1'b0;
    tick(10);

    force dut.r_step_count = 16'hFFFF;
    #1;
    release dut.r_step_count;
    @(negedge clk);
    chk("wrap_pre", 32'(mif.step_count), 32'hFFFF);
    press("wrap", 7, 10, 16'h0000);
    mif.step_btn = 1'b0;
    tick(70);
    chk("wrap_shown", mif.shown, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
